// File: rtl/tx_ethernet.sv
// GMII transmit MAC framer: preamble/SFD, header, streamed payload, zero pad,
// CRC-32 FCS, inter-frame gap, with completion irq and underrun abort.
module tx_ethernet (
  input  logic        TX_CLK,
  input  logic        rst_n,
  input  logic [47:0] mac_addr,
  input  logic [47:0] tx_mac_dst,
  input  logic [15:0] tx_len_type,
  input  logic        tx_start,
  output logic        tx_busy,
  input  logic [7:0]  tx_payload,
  input  logic        tx_payload_valid,
  input  logic        tx_payload_last,
  output logic        tx_payload_ready,
  output logic [7:0]  TXD,
  output logic        TX_EN,
  output logic        TX_ER,
  output logic        tx_ethernet_irq,
  output logic        tx_underrun
);

  localparam int          OCT         = 8;
  localparam logic [7:0]  PRE         = 8'b10101010;
  localparam logic [7:0]  SFD         = 8'b10101011;
  localparam logic [15:0] MIN_PAYLOAD = 16'd46;
  localparam int          IFG         = 12;
  localparam logic [3:0]  IFG_LAST    = 4'(IFG - 1);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_LEN, S_DATA, S_PAD, S_FCS, S_GAP
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  oct_cnt;
  logic [15:0] pay_cnt;
  logic [31:0] crc;
  logic [47:0] dst_q;
  logic [15:0] len_q;
  logic        abort_q;

  logic [7:0]  txd_nx;
  logic        en_nx, er_nx, crc_en;
  logic        accept, hs, starve;
  logic [47:0] dst_sh, src_sh;
  logic [15:0] len_sh;
  logic [31:0] fcs_sh;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < OCT; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept           = (state == S_IDLE) && tx_start;
  assign tx_payload_ready = (state == S_DATA);
  assign hs               = tx_payload_ready && tx_payload_valid;
  assign starve           = tx_payload_ready && !tx_payload_valid;

  // Multi-octet fields go out most significant octet first; FCS goes LSB first.
  assign dst_sh = dst_q << {oct_cnt, 3'b000};
  assign src_sh = mac_addr << {oct_cnt, 3'b000};
  assign len_sh = len_q << {oct_cnt, 3'b000};
  assign fcs_sh = ~crc >> {oct_cnt, 3'b000};

  always_ff @(posedge TX_CLK or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (tx_start) state_nx = S_PRE;
      S_PRE:  if (oct_cnt == 4'd6) state_nx = S_SFD;
      S_SFD:  state_nx = S_DST;
      S_DST:  if (oct_cnt == 4'd5) state_nx = S_SRC;
      S_SRC:  if (oct_cnt == 4'd5) state_nx = S_LEN;
      S_LEN:  if (oct_cnt == 4'd1) state_nx = S_DATA;
      S_DATA: begin
        if (!tx_payload_valid)
          state_nx = S_GAP;
        else if (tx_payload_last)
          state_nx = (pay_cnt < MIN_PAYLOAD - 16'd1) ? S_PAD : S_FCS;
      end
      S_PAD:  if (pay_cnt >= MIN_PAYLOAD - 16'd1) state_nx = S_FCS;
      S_FCS:  if (oct_cnt == 4'd3) state_nx = S_GAP;
      S_GAP:  if (oct_cnt == IFG_LAST) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    txd_nx = 8'h00;
    en_nx  = 1'b0;
    er_nx  = 1'b0;
    crc_en = 1'b0;
    case (state)
      S_PRE: begin txd_nx = PRE;          en_nx = 1'b1; end
      S_SFD: begin txd_nx = SFD;          en_nx = 1'b1; end
      S_DST: begin txd_nx = dst_sh[47:40]; en_nx = 1'b1; crc_en = 1'b1; end
      S_SRC: begin txd_nx = src_sh[47:40]; en_nx = 1'b1; crc_en = 1'b1; end
      S_LEN: begin txd_nx = len_sh[15:8];  en_nx = 1'b1; crc_en = 1'b1; end
      S_DATA: begin
        en_nx = 1'b1;
        if (tx_payload_valid) begin
          txd_nx = tx_payload;
          crc_en = 1'b1;
        end else begin
          er_nx = 1'b1;
        end
      end
      S_PAD: begin en_nx = 1'b1; crc_en = 1'b1; end
      S_FCS: begin txd_nx = fcs_sh[7:0]; en_nx = 1'b1; end
      default: ;
    endcase
  end

  // Output stage: everything visible on GMII is registered one cycle behind state.
  always_ff @(posedge TX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      TXD             <= 8'h00;
      TX_EN           <= 1'b0;
      TX_ER           <= 1'b0;
      tx_busy         <= 1'b0;
      tx_ethernet_irq <= 1'b0;
      tx_underrun     <= 1'b0;
      oct_cnt         <= 4'd0;
      pay_cnt         <= 16'd0;
      crc             <= 32'hFFFFFFFF;
      dst_q           <= 48'd0;
      len_q           <= 16'd0;
      abort_q         <= 1'b0;
    end else begin
      TXD             <= txd_nx;
      TX_EN           <= en_nx;
      TX_ER           <= er_nx;
      tx_busy         <= (state != S_IDLE);
      tx_underrun     <= starve;
      tx_ethernet_irq <= (state == S_GAP) && (oct_cnt == 4'd0) && !abort_q;
      oct_cnt         <= (state_nx != state || state == S_IDLE) ? 4'd0 : oct_cnt + 4'd1;
      if (accept) begin
        dst_q   <= tx_mac_dst;
        len_q   <= tx_len_type;
        pay_cnt <= 16'd0;
        crc     <= 32'hFFFFFFFF;
        abort_q <= 1'b0;
      end else begin
        if (crc_en)               crc     <= crc32_byte(crc, txd_nx);
        if (hs || state == S_PAD) pay_cnt <= sat_inc16(pay_cnt);
        if (starve)               abort_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_ethernet.sv
// Directed bench for tx_ethernet: reset, full/padded/underrun frames,
// start-while-busy rejection and back-to-back start.
module tb_tx_ethernet;

  logic        TX_CLK = 1'b0;
  logic        rst_n;
  logic [47:0] mac_addr;
  logic [47:0] tx_mac_dst;
  logic [15:0] tx_len_type;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  tx_payload;
  logic        tx_payload_valid;
  logic        tx_payload_last;
  logic        tx_payload_ready;
  logic [7:0]  TXD;
  logic        TX_EN;
  logic        TX_ER;
  logic        tx_ethernet_irq;
  logic        tx_underrun;

  always #5 TX_CLK = ~TX_CLK;

  tx_ethernet dut (
    .TX_CLK(TX_CLK), .rst_n(rst_n), .mac_addr(mac_addr), .tx_mac_dst(tx_mac_dst),
    .tx_len_type(tx_len_type), .tx_start(tx_start), .tx_busy(tx_busy),
    .tx_payload(tx_payload), .tx_payload_valid(tx_payload_valid),
    .tx_payload_last(tx_payload_last), .tx_payload_ready(tx_payload_ready),
    .TXD(TXD), .TX_EN(TX_EN), .TX_ER(TX_ER),
    .tx_ethernet_irq(tx_ethernet_irq), .tx_underrun(tx_underrun)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  cap[$];
  logic [7:0]  exp_q[$];
  logic [31:0] exp_fcs;
  int en_cyc, irq_cnt, und_cnt, er_cnt, er_txd_bad;
  int first_en, en_fall, irq_at, busy_fall, stray;
  bit timeout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge TX_CLK);
    #1;
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++)
      r = {1'b0, r[31:1]} ^ (r[0] ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  function automatic logic [8:0] cap_at(input int i);
    if (i >= 0 && i < cap.size()) return {1'b0, cap[i]};
    return 9'h1FF;
  endfunction

  function automatic logic [31:0] cap_fcs();
    int n;
    n = cap.size();
    if (n < 4) return 32'hDEADBEEF;
    return {cap[n-1], cap[n-2], cap[n-3], cap[n-4]};
  endfunction

  task automatic build_exp(input int n, input logic [47:0] dst, input logic [15:0] lt);
    logic [31:0] c;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'hAA);
    exp_q.push_back(8'hAB);
    for (int i = 0; i < 6; i++) exp_q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(mac_addr[47-8*i -: 8]);
    exp_q.push_back(lt[15:8]);
    exp_q.push_back(lt[7:0]);
    for (int i = 0; i < n; i++) exp_q.push_back(8'(i));
    for (int i = n; i < 46; i++) exp_q.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < exp_q.size(); i++) c = crc_step(c, exp_q[i]);
    exp_fcs = ~c;
    exp_q.push_back(exp_fcs[7:0]);
    exp_q.push_back(exp_fcs[15:8]);
    exp_q.push_back(exp_fcs[23:16]);
    exp_q.push_back(exp_fcs[31:24]);
  endtask

  task automatic cmp_bytes(input string tag, input int lo, input int hi);
    int bad;
    bad = 0;
    for (int i = lo; i < hi; i++)
      if (cap_at(i) !== {1'b0, exp_q[i]}) bad++;
    chk(tag, bad, 0);
  endtask

  // Drives one frame (or follows one already accepted) until tx_busy falls.
  task automatic run_frame(input int n, input int stall_at, input bit started,
                           input bit poke, input bit hold);
    int  idx, c;
    bit  seen_busy, hs;
    idx = 0; c = 0; seen_busy = 0;
    cap.delete();
    en_cyc = 0; irq_cnt = 0; und_cnt = 0; er_cnt = 0; er_txd_bad = 0;
    first_en = -1; en_fall = -1; irq_at = -1; busy_fall = -1; timeout = 0;
    if (!started) begin
      tx_start = 1'b1;
      tick();
    end
    tx_start = 1'b0;
    while (!(seen_busy && !tx_busy)) begin
      if (c > 3000) begin
        timeout = 1;
        break;
      end
      if (idx < n && (stall_at < 0 || idx < stall_at)) begin
        tx_payload_valid = 1'b1;
        tx_payload       = 8'(idx);
        tx_payload_last  = (idx == n - 1);
      end else begin
        tx_payload_valid = 1'b0;
        tx_payload       = 8'h00;
        tx_payload_last  = 1'b0;
      end
      tx_start = (poke && c == 29) || (poke && en_fall >= 0 && c == en_fall + 3) ||
                 (hold && en_fall >= 0 && c >= en_fall + 2);
      hs = tx_payload_ready && tx_payload_valid;
      tick();
      c++;
      if (hs) idx++;
      if (tx_busy) seen_busy = 1;
      if (TX_EN) begin
        cap.push_back(TXD);
        en_cyc++;
        if (first_en < 0) first_en = c;
      end else if (first_en >= 0 && en_fall < 0) begin
        en_fall = c;
      end
      if (TX_ER) begin
        er_cnt++;
        if (TXD !== 8'h00) er_txd_bad++;
      end
      if (tx_ethernet_irq) begin
        irq_cnt++;
        irq_at = c;
      end
      if (tx_underrun) und_cnt++;
    end
    busy_fall = c;
    if (!hold) tx_start = 1'b0;
  endtask

  task automatic check_good(input string tag, input int n_on);
    int sz;
    sz = exp_q.size();
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_first_en"}, first_en, 1);
    chk({tag, "_len"}, cap.size(), sz);
    cmp_bytes({tag, "_hdr"}, 0, 22);
    cmp_bytes({tag, "_body"}, 22, sz - 4);
    chk({tag, "_fcs"}, cap_fcs(), exp_fcs);
    chk({tag, "_en_cycles"}, en_cyc, n_on);
    chk({tag, "_en_contig"}, en_fall - first_en, n_on);
    chk({tag, "_irq_cnt"}, irq_cnt, 1);
    chk({tag, "_irq_at"}, irq_at, en_fall);
    chk({tag, "_gap"}, busy_fall - en_fall, 12);
    chk({tag, "_er"}, er_cnt, 0);
    chk({tag, "_underrun"}, und_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    mac_addr = 48'h02_00_00_00_00_01;
    tx_mac_dst = 48'hFF_FF_FF_FF_FF_FF;
    tx_len_type = 16'h0800;
    tx_start = 1'b0;
    tx_payload = 8'h00;
    tx_payload_valid = 1'b0;
    tx_payload_last = 1'b0;
    tick();
    tick();
    chk("rst_txd", TXD, 8'h00);
    chk("rst_en", TX_EN, 1'b0);
    chk("rst_er", TX_ER, 1'b0);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_ready", tx_payload_ready, 1'b0);
    chk("rst_irq", tx_ethernet_irq, 1'b0);
    chk("rst_underrun", tx_underrun, 1'b0);
    rst_n = 1'b1;
    tick();

    // Reset during the preamble drops outputs asynchronously.
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tick(); tick(); tick();
    chk("pre_en_before_rst", TX_EN, 1'b1);
    chk("pre_txd_before_rst", TXD, 8'hAA);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_en", TX_EN, 1'b0);
    chk("async_rst_txd", TXD, 8'h00);
    chk("async_rst_busy", tx_busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("no_resume_en", TX_EN, 1'b0);
    chk("no_resume_busy", tx_busy, 1'b0);

    // Broadcast IPv4 frame with a 60-byte payload.
    build_exp(60, tx_mac_dst, tx_len_type);
    run_frame(60, -1, 0, 0, 0);
    check_good("f60", 86);

    // Short payload is zero padded to 46 bytes.
    tx_mac_dst = 48'h00_11_22_33_44_55;
    tx_len_type = 16'h000A;
    build_exp(10, tx_mac_dst, tx_len_type);
    run_frame(10, -1, 0, 0, 0);
    check_good("f10", 72);

    // Source starves after 20 bytes: abort with a single error octet.
    tx_mac_dst = 48'hA1_B2_C3_D4_E5_F6;
    tx_len_type = 16'h86DD;
    build_exp(60, tx_mac_dst, tx_len_type);
    run_frame(60, 20, 0, 0, 0);
    chk("urun_timeout", timeout, 0);
    chk("urun_len", cap.size(), 43);
    cmp_bytes("urun_hdr_payload", 0, 42);
    chk("urun_err_byte", cap_at(42), 9'h000);
    chk("urun_er_cnt", er_cnt, 1);
    chk("urun_er_txd", er_txd_bad, 0);
    chk("urun_pulse", und_cnt, 1);
    chk("urun_irq", irq_cnt, 0);
    chk("urun_gap", busy_fall - en_fall, 12);

    // Starts while busy (mid-frame and during the gap) are dropped.
    tx_mac_dst = 48'h01_02_03_04_05_06;
    tx_len_type = 16'h0806;
    build_exp(46, tx_mac_dst, tx_len_type);
    run_frame(46, -1, 0, 1, 0);
    check_good("poke", 72);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (TX_EN || tx_busy) stray++;
    end
    chk("poke_no_second_frame", stray, 0);

    // A start held through the gap launches the next frame right away.
    build_exp(46, tx_mac_dst, tx_len_type);
    run_frame(46, -1, 0, 0, 1);
    check_good("hold_a", 72);
    tx_mac_dst = 48'hDE_AD_BE_EF_00_42;
    tx_len_type = 16'h0032;
    build_exp(46, 48'h01_02_03_04_05_06, 16'h0806);
    run_frame(50, -1, 1, 0, 0);
    build_exp(50, 48'h01_02_03_04_05_06, 16'h0806);
    check_good("hold_b", 76);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_ethernet.md
# tx_ethernet

GMII transmit-side Ethernet MAC framer: the transmit counterpart of the receive MAC in the Vthernet MAC. On a start request it latches the destination MAC and length/type, then emits preamble, SFD, destination, source (local `mac_addr`), length/type, streamed payload, zero padding to the 46-byte minimum, and FCS on `TXD`/`TX_EN`. It then enforces the inter-frame gap and pulses an interrupt on completion. Upper layers, such as the IPv4 transmit logic, feed payload bytes through a valid/ready stream.

## Interface
- `OCT`, 8, bits per octet
- `PRE`, 8'b10101010, preamble octet, sent 7 times
- `SFD`, 8'b10101011, start-of-frame delimiter
- `MIN_PAYLOAD`, 46, minimum payload bytes; shorter payloads are zero-padded
- `IFG`, 12, inter-frame gap in TX_CLK cycles with TX_EN low

Ports:
- `TX_CLK`  in  1  GMII transmit clock; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `mac_addr`  in  48  local MAC, used as the source address; MSB octet is sent first
- `tx_mac_dst`  in  48  destination MAC; latched on start
- `tx_len_type`  in  16  length/type; latched on start; high octet is sent first
- `tx_start`  in  1  frame request; honoured only when `tx_busy`=0
- `tx_busy`  out  1  high from accepted start through the end of the IFG
- `tx_payload`  in  8  payload byte
- `tx_payload_valid`  in  1  payload byte valid
- `tx_payload_last`  in  1  marks the final payload byte
- `tx_payload_ready`  out  1  payload byte accepted when valid&ready
- `TXD`  out  8  GMII transmit data
- `TX_EN`  out  1  GMII transmit enable
- `TX_ER`  out  1  GMII transmit error
- `tx_ethernet_irq`  out  1  one-cycle pulse on successful frame completion
- `tx_underrun`  out  1  one-cycle pulse on aborted frame

## Operation
- Reset values: `TXD`=0, `TX_EN`=0, `TX_ER`=0, `tx_busy`=0, `tx_payload_ready`=0, irq=0, underrun=0, state IDLE, counters 0, CRC=32'hFFFFFFFF.
- Reset asserted mid-frame: all outputs drop immediately to their reset values. After release, no partial frame resumes.
- All GMII outputs and the irq/underrun pulses are registered. `tx_payload_ready` is a decode of the state (DATA) only.
- State machine:
  - IDLE: `tx_start`=1 → latch dst and len/type; clear counters; CRC←FFFFFFFF; go to PREAMBLE.
  - PREAMBLE: 7 cycles of `PRE`, then SFD.
  - SFD: 1 cycle of `SFD`, then MAC_DST.
  - MAC_DST: 6 octets, then MAC_SRC.
  - MAC_SRC: 6 octets of `mac_addr`, then LEN_TYPE.
  - LEN_TYPE: 2 octets, then DATA.
  - DATA: each handshake drives `TXD`=`tx_payload` next cycle and increments the 16-bit payload counter.
    - Handshake with last=1 → go to PAD if count+1 < `MIN_PAYLOAD`, else to FCS.
    - valid=0 in DATA → underrun.
  - PAD: drive 8'h00 until the total payload reaches `MIN_PAYLOAD`, then FCS.
  - FCS: 4 octets, then GAP.
  - GAP: `TX_EN`=0 for `IFG` cycles, then IDLE.
- CRC: IEEE 802.3 CRC-32, reflected polynomial 32'hEDB88320, init FFFFFFFF.
  - Updated byte-serially (bit 0 first) on every octet from dst through pad.
  - FCS = ~CRC, sent as octet [7:0] first, then [15:8], [23:16], [31:24].
  - Preamble and SFD are excluded from the CRC.
- Underrun: valid=0 while ready=1 (the DATA state).
  - Next cycle: `TX_EN`=1, `TX_ER`=1, `TXD`=0; `tx_underrun` pulses.
  - Then go to GAP; no FCS is sent and no irq is raised.
- irq pulses the cycle after the last FCS octet is driven, i.e. the first GAP cycle. It never pulses on an aborted frame.
- `tx_start` while `tx_busy`=1 is ignored, not queued.
- Payload count saturates at 16'hFFFF. There is no maximum-length check; that belongs to the upper layer.

## Timing
- Start sampled at edge k: `tx_busy`=1 and the first `PRE` octet on `TXD` with `TX_EN`=1 from edge k+1.
- Octet placement:
  - k+1..k+7: `PRE`
  - k+8: `SFD`
  - k+9..k+14: dst
  - k+15..k+20: src
  - k+21..k+22: len/type
- `tx_payload_ready`=1 from edge k+22 (while the second len/type octet is on `TXD`). With an always-valid source, payload byte i appears on `TXD` at k+23+i.
- Frame with N ≥ 46 payload bytes: `TX_EN` high for 8+14+N+4 cycles contiguously. `TX_EN` falls after the last FCS octet.
- `tx_busy` falls `IFG` cycles after `TX_EN` falls. The earliest next start is accepted on that edge.
- `TX_ER`=0 at all times except the single underrun cycle.

## Test plan
- Reset mid-preamble (`rst_n` low at k+4) → `TX_EN`/`TXD`/`tx_busy` are 0 asynchronously, before the next edge. After release, the next `tx_start` yields a clean frame.
- Start with dst=FF:FF:FF:FF:FF:FF, `mac_addr`=02:00:00:00:00:01, type 16'h0800, 60-byte continuous payload 0..59:
  - `TXD` sequence is AA×7, AB, FF×6, 02 00 00 00 00 01, 08 00, 00..3B, then 4 FCS octets.
  - FCS matches the golden CRC-32 model.
  - `TX_EN` is high for 86 cycles; irq pulses once; `tx_busy` is low 12 cycles after `TX_EN` falls.
- 10-byte payload, last on byte 10 → 36 octets of 00 pad follow the payload; the FCS covers the pad; `TX_EN` is high for 72 cycles.
- Source deasserts valid after 20 bytes (last not yet seen) → one cycle with `TX_ER`=1, `TXD`=00; `tx_underrun` pulses; irq stays 0; no FCS is sent; 12-cycle gap; `tx_busy` then falls.
- Backpressure-free stalls are not allowed, so check the start-while-busy case: `tx_start` pulsed at k+30 and again during the gap → both ignored, no second frame. A `tx_start` held until `tx_busy` falls produces a second frame starting exactly 1 cycle later.
